// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_seq_pkg;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  localparam logic [9:0] PROG0_START = 10'd0;
  localparam logic [9:0] PROG1_START = 10'd256;
  localparam logic [9:0] PROG2_START = 10'd512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: launches three programs in turn,
// steps/branches the PC and counts executed instructions.
module pc_sequencer #(
  parameter int              PC_W        = pc_seq_pkg::PC_W,
  parameter logic [PC_W-1:0] PROG0_START = PC_W'(pc_seq_pkg::PROG0_START),
  parameter logic [PC_W-1:0] PROG1_START = PC_W'(pc_seq_pkg::PROG1_START),
  parameter logic [PC_W-1:0] PROG2_START = PC_W'(pc_seq_pkg::PROG2_START),
  parameter int              CNT_W       = pc_seq_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic             branch_en,
  input  logic             branch_taken,
  input  logic [2:0]       branch_ptr,
  input  logic [PC_W-1:0]  target,
  output logic [2:0]       lut_addr,
  output logic [1:0]       prog_state,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             ack,
  output logic [CNT_W-1:0] cycle_count
);

  import pc_seq_pkg::*;

  state_t          state, state_n;
  logic [PC_W-1:0] pc_n;
  logic [1:0]      prog_n;
  logic            armed;
  logic            go;
  logic            cnt_clr;
  logic            cnt_en;

  function automatic logic [PC_W-1:0] start_addr(input logic [1:0] p);
    case (p)
      2'd1:    return PROG1_START;
      2'd2:    return PROG2_START;
      default: return PROG0_START;
    endcase
  endfunction

  // armed blocks a start seen on the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed      <= 1'b0;
      state      <= IDLE;
      pc         <= '0;
      prog_state <= 2'd0;
    end else begin
      armed      <= 1'b1;
      state      <= state_n;
      pc         <= pc_n;
      prog_state <= prog_n;
    end
  end

  assign go = start && armed;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    prog_n  = prog_state;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          prog_n  = (prog_state == 2'd3) ? 2'd0 : prog_state;
          pc_n    = start_addr(prog_n);
          cnt_clr = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        if (halt) begin
          state_n = DONE;
        end else if (branch_en && branch_taken) begin
          pc_n = target;
        end else begin
          pc_n = pc + 1'b1;
        end
      end
      DONE: begin
        if (go) begin
          prog_n  = (prog_state >= 2'd2) ? 2'd0 : prog_state + 2'd1;
          pc_n    = start_addr(prog_n);
          cnt_clr = 1'b1;
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .q   (cycle_count)
  );

  assign lut_addr = branch_ptr;
  assign running  = (state == RUN);
  assign ack      = (state == DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        branch_en = 1'b0;
  logic        branch_taken = 1'b0;
  logic [2:0]  branch_ptr = 3'd0;
  logic [9:0]  target = 10'd0;
  logic [2:0]  lut_addr;
  logic [1:0]  prog_state;
  logic [9:0]  pc;
  logic        running;
  logic        ack;
  logic [15:0] cycle_count;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .halt         (halt),
    .branch_en    (branch_en),
    .branch_taken (branch_taken),
    .branch_ptr   (branch_ptr),
    .target       (target),
    .lut_addr     (lut_addr),
    .prog_state   (prog_state),
    .pc           (pc),
    .running      (running),
    .ack          (ack),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reset, release, then launch program 0
  task automatic relaunch();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_pc", pc, 0);
    chk("rst_prog", prog_state, 0);
    chk("rst_running", running, 0);
    chk("rst_ack", ack, 0);
    chk("rst_cnt", cycle_count, 0);

    // start on the release edge is ignored
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rel_start_ignored", running, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("launch_pc", pc, 0);
    chk("launch_run", running, 1);
    chk("launch_cnt", cycle_count, 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("seq_pc", pc, i);
    end
    chk("seq_running", running, 1);
    chk("seq_cnt", cycle_count, 5);

    // not-taken branch at PC=3
    relaunch();
    repeat (3) step();
    chk("pre_br_pc", pc, 3);
    branch_en = 1'b1;
    branch_taken = 1'b0;
    target = 10'd40;
    branch_ptr = 3'd5;
    #1;
    chk("lut_addr", lut_addr, 5);
    step();
    chk("br_not_taken", pc, 4);

    // taken branch at PC=3
    branch_en = 1'b0;
    relaunch();
    repeat (3) step();
    branch_en = 1'b1;
    branch_taken = 1'b1;
    target = 10'd40;
    step();
    chk("br_taken", pc, 40);
    branch_en = 1'b0;
    branch_taken = 1'b0;

    // halt beats a taken branch
    relaunch();
    repeat (7) step();
    chk("pre_halt_pc", pc, 7);
    halt = 1'b1;
    branch_en = 1'b1;
    branch_taken = 1'b1;
    target = 10'd99;
    step();
    halt = 1'b0;
    branch_en = 1'b0;
    branch_taken = 1'b0;
    chk("halt_pc", pc, 7);
    chk("halt_ack", ack, 1);
    chk("halt_running", running, 0);
    chk("halt_cnt", cycle_count, 8);
    step();
    chk("done_pc_hold", pc, 7);
    chk("done_cnt_hold", cycle_count, 8);

    // program rotation 1, 2, 0
    start = 1'b1;
    step();
    start = 1'b0;
    chk("p1_prog", prog_state, 1);
    chk("p1_pc", pc, 256);
    chk("p1_cnt", cycle_count, 0);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk("p1_ack", ack, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("p2_prog", prog_state, 2);
    chk("p2_pc", pc, 512);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run_start_pc", pc, 513);
    chk("run_start_prog", prog_state, 2);
    chk("run_start_running", running, 1);
    halt = 1'b1;
    step();
    halt = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("p0_prog", prog_state, 0);
    chk("p0_pc", pc, 0);

    // reset mid-run at PC=300
    halt = 1'b1;
    step();
    halt = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("p1b_pc", pc, 256);
    repeat (44) step();
    chk("pre_rst_pc", pc, 300);
    rst = 1'b1;
    #1;
    chk("async_pc", pc, 0);
    chk("async_prog", prog_state, 0);
    chk("async_ack", ack, 0);
    chk("async_running", running, 0);
    chk("async_cnt", cycle_count, 0);

    // PC wrap and counter saturation
    relaunch();
    repeat (1023) step();
    chk("pc_1023", pc, 1023);
    step();
    chk("pc_wrap", pc, 0);
    chk("cnt_1024", cycle_count, 1024);
    repeat (64510) step();
    chk("cnt_fffe", cycle_count, 16'hFFFE);
    step();
    chk("cnt_ffff", cycle_count, 16'hFFFF);
    repeat (5) step();
    chk("cnt_sat", cycle_count, 16'hFFFF);
    chk("pc_after_sat", pc, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
